// File: rtl/tdm_pkg.sv
// Shared definitions for the four-slot TDM receive path: slot count, FSM states
// and width helpers derived from the slot width.
package tdm_pkg;

   localparam int NSLOT = 4;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int frameLen(input int slotW);
      return NSLOT * slotW;
   endfunction

   // Bits needed to index 0..n-1, never less than one.
   function automatic int idxWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int SIDX_W = idxWidth(NSLOT);

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer; the source side drives
// the serial stream and enable, the demultiplexer returns the frame words and status.
interface tdm_demux4_if #(
   parameter int SLOT_W = 8
);

   logic              Gbar;
   logic              DIN;
   logic              FSYNC;
   logic [SLOT_W-1:0] Y0;
   logic [SLOT_W-1:0] Y1;
   logic [SLOT_W-1:0] Y2;
   logic [SLOT_W-1:0] Y3;
   logic              VALID;
   logic              SYNC_ERR;
   logic              LOCKED;

   modport master (
      output Gbar, DIN, FSYNC,
      input  Y0, Y1, Y2, Y3, VALID, SYNC_ERR, LOCKED
   );

   modport slave (
      input  Gbar, DIN, FSYNC,
      output Y0, Y1, Y2, Y3, VALID, SYNC_ERR, LOCKED
   );

endinterface

// File: rtl/tdm_deser.sv
// Slot deserialiser: frame bit counter plus the shift register that assembles each
// slot MSB first. The word presented includes the bit arriving this cycle.
module tdm_deser
   import tdm_pkg::*;
#(
   parameter int SLOT_W = 8
) (
   input  logic              CLK,
   input  logic              i_clear,
   input  logic              i_start,
   input  logic              i_shift,
   input  logic              i_din,
   output logic              o_atStart,
   output logic              o_slotDone,
   output logic              o_frameDone,
   output logic [SIDX_W-1:0] o_slotIdx,
   output logic [SLOT_W-1:0] o_word
);

   localparam int FRAME_LEN = frameLen(SLOT_W);
   localparam int CNT_W     = idxWidth(FRAME_LEN);
   localparam int SH_W      = SLOT_W - 1;

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] SLOT_LEN  = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_W - 1);

   logic [CNT_W-1:0] r_count;
   logic [SH_W-1:0]  r_shift;
   logic [CNT_W-1:0] w_slot;
   logic [CNT_W-1:0] w_bitPos;

   // Only SLOT_W-1 history bits are stored; the final bit is taken live from DIN.
   assign o_word      = {r_shift, i_din};
   assign w_slot      = r_count / SLOT_LEN;
   assign w_bitPos    = r_count % SLOT_LEN;
   assign o_slotIdx   = SIDX_W'(w_slot);
   assign o_atStart   = (r_count == '0);
   assign o_slotDone  = (w_bitPos == SLOT_LAST);
   assign o_frameDone = (r_count == LAST_CNT);

   // A start bit is shifted like any other but forces the counter to position one.
   always_ff @(posedge CLK) begin
      if (i_clear) begin
         r_count <= '0;
         r_shift <= '0;
      end else if (i_start) begin
         r_count <= CNT_W'(1);
         r_shift <= o_word[SH_W-1:0];
      end else if (i_shift) begin
         r_count <= o_frameDone ? '0 : r_count + CNT_W'(1);
         r_shift <= o_word[SH_W-1:0];
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: frame-sync hunting FSM, per-slot staging,
// parallel output registers and active-low output enable.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int SLOT_W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   tdm_demux4_if.slave  bus
);

   state_t            r_state;
   logic              r_valid;
   logic              r_syncErr;
   logic              r_locked;
   logic [SLOT_W-1:0] r_y     [NSLOT];
   logic [SLOT_W-1:0] r_stage [NSLOT];

   logic              w_atStart;
   logic              w_slotDone;
   logic              w_frameDone;
   logic [SIDX_W-1:0] w_slotIdx;
   logic [SLOT_W-1:0] w_word;
   logic              w_missSync;
   logic              w_clear;
   logic              w_start;
   logic              w_shift;

   // Deserialiser control follows the FSM priority: reset, enable, sync checks, shift.
   assign w_missSync = (r_state == RUN) && w_atStart && !bus.FSYNC;
   assign w_clear    = RST || bus.Gbar || w_missSync;
   assign w_start    = !w_clear && bus.FSYNC;
   assign w_shift    = !w_clear && !bus.FSYNC && (r_state == RUN);

   tdm_deser #(
      .SLOT_W (SLOT_W)
   ) u_deser (
      .CLK         (CLK),
      .i_clear     (w_clear),
      .i_start     (w_start),
      .i_shift     (w_shift),
      .i_din       (bus.DIN),
      .o_atStart   (w_atStart),
      .o_slotDone  (w_slotDone),
      .o_frameDone (w_frameDone),
      .o_slotIdx   (w_slotIdx),
      .o_word      (w_word)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= HUNT;
         r_valid   <= 1'b0;
         r_syncErr <= 1'b0;
         r_locked  <= 1'b0;
         for (int k = 0; k < NSLOT; k++) begin
            r_y[k]     <= '0;
            r_stage[k] <= '0;
         end
      end else if (bus.Gbar) begin
         // Output words are held so they reappear once the enable returns.
         r_state   <= HUNT;
         r_valid   <= 1'b0;
         r_syncErr <= 1'b0;
         r_locked  <= 1'b0;
         for (int k = 0; k < NSLOT; k++) begin
            r_stage[k] <= '0;
         end
      end else begin
         r_valid   <= 1'b0;
         r_syncErr <= 1'b0;
         case (r_state)
            HUNT: begin
               if (bus.FSYNC) begin
                  r_state  <= RUN;
                  r_locked <= 1'b1;
               end
            end
            RUN: begin
               if (w_missSync) begin
                  r_syncErr <= 1'b1;
                  r_state   <= HUNT;
                  r_locked  <= 1'b0;
               end else if (bus.FSYNC && !w_atStart) begin
                  r_syncErr <= 1'b1;
               end else if (w_slotDone) begin
                  r_stage[w_slotIdx] <= w_word;
                  if (w_frameDone) begin
                     for (int k = 0; k < NSLOT - 1; k++) begin
                        r_y[k] <= r_stage[k];
                     end
                     r_y[NSLOT-1] <= w_word;
                     r_valid      <= 1'b1;
                  end
               end
            end
            default: begin
               r_state  <= HUNT;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Y0       = bus.Gbar ? '0 : r_y[0];
   assign bus.Y1       = bus.Gbar ? '0 : r_y[1];
   assign bus.Y2       = bus.Gbar ? '0 : r_y[2];
   assign bus.Y3       = bus.Gbar ? '0 : r_y[3];
   assign bus.VALID    = r_valid;
   assign bus.SYNC_ERR = r_syncErr;
   assign bus.LOCKED   = r_locked;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 with 8-bit slots: directed frames, resync, missing sync,
// enable gating and reset, checked against a bit-queue frame model every cycle.
module tb_tdm_demux4;

   localparam int SW = 8;
   localparam int FL = 4 * SW;

   logic CLK = 1'b0;
   logic RST;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   tdm_demux4_if #(.SLOT_W(SW)) bus ();

   tdm_demux4 #(
      .SLOT_W (SW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // Frame model: collect the bits since the last accepted sync and slice them into words.
   logic          mReady  = 1'b0;
   logic          mValid  = 1'b0;
   logic          mErr    = 1'b0;
   logic          mLocked = 1'b0;
   logic [SW-1:0] mY [4];
   logic          mBits [$];

   always @(posedge CLK) begin
      if (RST) begin
         mValid  = 1'b0;
         mErr    = 1'b0;
         mLocked = 1'b0;
         mBits.delete();
         for (int k = 0; k < 4; k++) mY[k] = '0;
         mReady  = 1'b1;
      end else if (bus.Gbar) begin
         mValid  = 1'b0;
         mErr    = 1'b0;
         mLocked = 1'b0;
         mBits.delete();
      end else begin
         mValid = 1'b0;
         mErr   = 1'b0;
         if (!mLocked) begin
            if (bus.FSYNC) begin
               mLocked = 1'b1;
               mBits.delete();
               mBits.push_back(bus.DIN);
            end
         end else if (mBits.size() == 0 && !bus.FSYNC) begin
            mErr    = 1'b1;
            mLocked = 1'b0;
         end else if (bus.FSYNC && mBits.size() != 0) begin
            mErr = 1'b1;
            mBits.delete();
            mBits.push_back(bus.DIN);
         end else begin
            mBits.push_back(bus.DIN);
            if (mBits.size() == FL) begin
               for (int k = 0; k < 4; k++)
                  for (int b = 0; b < SW; b++)
                     mY[k][SW-1-b] = mBits[k*SW + b];
               mValid = 1'b1;
               mBits.delete();
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (mReady) begin
         checkOutput("VALID",    32'(bus.VALID),    32'(mValid));
         checkOutput("SYNC_ERR", 32'(bus.SYNC_ERR), 32'(mErr));
         checkOutput("LOCKED",   32'(bus.LOCKED),   32'(mLocked));
         checkOutput("Y0", 32'(bus.Y0), bus.Gbar ? 32'd0 : 32'(mY[0]));
         checkOutput("Y1", 32'(bus.Y1), bus.Gbar ? 32'd0 : 32'(mY[1]));
         checkOutput("Y2", 32'(bus.Y2), bus.Gbar ? 32'd0 : 32'(mY[2]));
         checkOutput("Y3", 32'(bus.Y3), bus.Gbar ? 32'd0 : 32'(mY[3]));
      end
   end

   task automatic applyStimulus(input logic rst, input logic gbar, input logic fsync, input logic din);
      @(posedge CLK);
      #1;
      RST       = rst;
      bus.Gbar  = gbar;
      bus.FSYNC = fsync;
      bus.DIN   = din;
   endtask

   // Sends nBits of a frame, MSB of slot 0 first; optionally pins the previous frame's outputs.
   task automatic sendFrame(input logic [31:0] frame, input int nBits, input logic chk, input logic [31:0] prev);
      for (int i = 0; i < nBits; i++) begin
         applyStimulus(1'b0, 1'b0, (i == 0), frame[31-i]);
         if (i == 0 && chk) begin
            #1;
            checkOutput("litValid",  32'(bus.VALID),  32'd1);
            checkOutput("litLocked", 32'(bus.LOCKED), 32'd1);
            checkOutput("litY0", 32'(bus.Y0), 32'(prev[31:24]));
            checkOutput("litY1", 32'(bus.Y1), 32'(prev[23:16]));
            checkOutput("litY2", 32'(bus.Y2), 32'(prev[15:8]));
            checkOutput("litY3", 32'(bus.Y3), 32'(prev[7:0]));
         end
      end
   endtask

   initial begin
      RST       = 1'b1;
      bus.Gbar  = 1'b0;
      bus.FSYNC = 1'b0;
      bus.DIN   = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("rstLocked", 32'(bus.LOCKED),   32'd0);
      checkOutput("rstValid",  32'(bus.VALID),    32'd0);
      checkOutput("rstErr",    32'(bus.SYNC_ERR), 32'd0);
      checkOutput("rstY0",     32'(bus.Y0),       32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      sendFrame(32'hA53CFF01, FL, 1'b0, 32'h0);
      sendFrame(32'h11121314, FL, 1'b1, 32'hA53CFF01);
      sendFrame(32'h21222324, FL, 1'b1, 32'h11121314);
      sendFrame(32'h31323334, FL, 1'b1, 32'h21222324);

      sendFrame(32'h41424344, 13, 1'b1, 32'h31323334);
      sendFrame(32'h66778899, FL, 1'b0, 32'h0);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("resyncValid", 32'(bus.VALID), 32'd1);
      checkOutput("resyncY0",    32'(bus.Y0),    32'h66);
      checkOutput("resyncY3",    32'(bus.Y3),    32'h99);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("missErr",    32'(bus.SYNC_ERR), 32'd1);
      checkOutput("missLocked", 32'(bus.LOCKED),   32'd0);
      checkOutput("missValid",  32'(bus.VALID),    32'd0);
      checkOutput("missY2",     32'(bus.Y2),       32'h88);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      sendFrame(32'hAABBCCDD, FL, 1'b0, 32'h0);
      sendFrame(32'hE1E2E3E4, 10, 1'b1, 32'hAABBCCDD);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      checkOutput("gbarY0",     32'(bus.Y0),     32'd0);
      checkOutput("gbarY3",     32'(bus.Y3),     32'd0);
      checkOutput("gbarLocked", 32'(bus.LOCKED), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      checkOutput("gbarLockedNext", 32'(bus.LOCKED), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("enY0",     32'(bus.Y0),     32'hAA);
      checkOutput("enY3",     32'(bus.Y3),     32'hDD);
      checkOutput("enLocked", 32'(bus.LOCKED), 32'd0);

      sendFrame(32'h5C5D5E5F, FL, 1'b0, 32'h0);
      sendFrame(32'h77665544, 20, 1'b1, 32'h5C5D5E5F);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("midRstY0",     32'(bus.Y0),     32'd0);
      checkOutput("midRstY1",     32'(bus.Y1),     32'd0);
      checkOutput("midRstLocked", 32'(bus.LOCKED), 32'd0);
      checkOutput("midRstValid",  32'(bus.VALID),  32'd0);

      sendFrame(32'hDEADBEEF, FL, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("lastValid", 32'(bus.VALID), 32'd1);
      checkOutput("lastY0",    32'(bus.Y0),    32'hDE);
      checkOutput("lastY3",    32'(bus.Y3),    32'hEF);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the serial TDM link fed by the team's 2:1/4:1 select-style multiplexers. Takes a single serial bit stream with a frame-sync marker and deserialises each frame's four slots into parallel channel words. Presents all four words together with a one-cycle valid strobe. Keeps the family's active-low output-enable (Gbar) semantics: Gbar high forces outputs to zero.

## Interface
- SLOT_W, default 8: bits per slot (channel word width), ≥2.
- CLK  in  1  rising-edge clock; all state updates on it.
- RST  in  1  synchronous, active-high reset.
- Gbar  in  1  active-low enable; 1 = disabled (outputs 0, framing aborted).
- DIN  in  1  serial data, one bit per CLK, MSB of slot 0 first.
- FSYNC  in  1  high for exactly the cycle carrying bit 0 (MSB) of slot 0.
- Y0, Y1, Y2, Y3  out  SLOT_W each  last completed frame, slots 0..3.
- VALID  out  1  one-cycle pulse: Y0..Y3 just updated with a new frame.
- SYNC_ERR  out  1  one-cycle pulse: framing violation detected.
- LOCKED  out  1  high while in RUN.

## Operation
- One clock; reset is synchronous and active-high (CLK, RST).
- Frame = 4 slots × SLOT_W bits = FRAME_LEN = 4·SLOT_W cycles, no gaps. Bit counter 0..FRAME_LEN-1; slot index = counter / SLOT_W.
- States: HUNT, RUN.
- HUNT: ignore DIN until FSYNC=1 with Gbar=0. That cycle's DIN is bit 0; counter := 1, → RUN.
- RUN: each cycle shift DIN into the slot shift register (MSB first), counter += 1. On the last bit of slot k (counter = k·SLOT_W + SLOT_W-1), the completed word goes to staging register k.
- Last bit of frame (counter = FRAME_LEN-1): on the next edge, Y0..Y2 load from staging, Y3 loads the just-completed word, VALID = 1, and the counter wraps to 0.
- Counter = 0 in RUN: FSYNC must be 1. If FSYNC=0: SYNC_ERR pulse, → HUNT, bit discarded.
- FSYNC=1 in RUN with counter ≠ 0: SYNC_ERR pulse and resync. The partial frame is discarded (no VALID), the current bit is taken as bit 0, counter := 1, stay in RUN.
- Gbar=1 in any state: next edge → HUNT, counter := 0, shift and staging contents discarded, VALID = SYNC_ERR = 0. Y0..Y3 read 0 combinationally while Gbar=1. Held Y registers are retained and reappear when Gbar returns to 0.
- Priority: RST > Gbar > FSYNC checks > normal shift.
- LOCKED = (state == RUN), registered.

## Timing
- Reset values: Y0..Y3 = 0, VALID = 0, SYNC_ERR = 0, LOCKED = 0, state HUNT, counter 0.
- FSYNC at cycle t → LOCKED = 1 from t+1. The frame's last bit is at t+FRAME_LEN-1; VALID and new Y at t+FRAME_LEN, same cycle as the next frame's FSYNC.
- Back-to-back frames give VALID every FRAME_LEN cycles. Y is stable between VALID pulses.
- SYNC_ERR asserts the cycle after the offending bit and lasts one cycle.
- A partial frame never produces VALID.
- Gbar affects Y with zero latency and state on the next edge.

## Structure
- Package tdm_pkg: NSLOT = 4, state enum {HUNT, RUN}, FRAME_LEN function of SLOT_W, slot-index width helper.
- Sub-module tdm_deser: SLOT_W shift register with bit counter, slot-done flag and slot index. The top level holds the FSM, staging/output registers, Gbar gating and error logic.

## Test plan
- SLOT_W=8: FSYNC + frame bits A5,3C,FF,01 → VALID one cycle at t+32, Y0..Y3 = A5,3C,FF,01, SYNC_ERR never set.
- Three back-to-back frames (11..14, 21..24, 31..34) → VALID at t+32, t+64, t+96, each with the correct Y. LOCKED stays 1 throughout.
- FSYNC re-asserted at counter 13 → SYNC_ERR at the next cycle, no VALID for the aborted frame. The frame starting at the new FSYNC decodes correctly.
- FSYNC missing at a frame boundary → SYNC_ERR pulse, LOCKED drops. Y holds the previous frame, and no VALID occurs until the next FSYNC plus 32 cycles.
- Gbar=1 mid-frame after a good frame → Y reads 0 immediately and LOCKED = 0 next cycle. With Gbar=0 again, Y shows the old frame and a new FSYNC frame decodes.
- RST asserted mid-frame and simultaneously with FSYNC → all outputs 0 next cycle, state HUNT, FSYNC that cycle ignored.
